// File: rtl/mcu_bus_pkg.sv
// Shared definitions for the memory bus arbiter: requester ids, DDR commands
// and the arbiter state encoding.
package mcu_bus_pkg;

    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_NONE = 2'd0;
    localparam req_id_t REQ_DSC  = 2'd1;
    localparam req_id_t REQ_PSC  = 2'd2;
    localparam req_id_t REQ_L2   = 2'd3;

    localparam logic [2:0] CMD_RD = 3'b001;
    localparam logic [2:0] CMD_WR = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        XFER = 2'd2,
        GAP  = 2'd3
    } state_t;

    // One-hot requester mask, bit 0 = DSC, bit 1 = PSC, bit 2 = L2.
    function automatic logic [2:0] id_mask(input req_id_t id);
        logic [2:0] m;
        m = 3'b000;
        case (id)
            REQ_DSC: m = 3'b001;
            REQ_PSC: m = 3'b010;
            REQ_L2:  m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and DDR user-port signals of the memory bus arbiter.
// master = requesters/DDR side, slave = the arbiter.
interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 28
);
    logic                  i_dsc_request;
    logic                  i_psc_request;
    logic                  i_l2_request;
    logic                  i_dsc_rw;
    logic                  i_psc_rw;
    logic                  i_l2_rw;
    logic [ADDR_WIDTH-1:0] i_dsc_addr;
    logic [ADDR_WIDTH-1:0] i_psc_addr;
    logic [ADDR_WIDTH-1:0] i_l2_addr;
    logic                  o_dsc_bus_available;
    logic                  o_psc_bus_available;
    logic                  o_l2_bus_available;
    logic                  o_dsc_done;
    logic                  o_psc_done;
    logic                  o_l2_done;
    logic [1:0]            o_grant_sel;
    logic                  i_ddr_ready;
    logic                  i_ddr_beat;
    logic                  o_ddr_op_en;
    logic [2:0]            o_ddr_op_cmd;
    logic [ADDR_WIDTH-1:0] o_ddr_op_addr;
    logic                  o_xfer_abort;

    modport master (
        output i_dsc_request, i_psc_request, i_l2_request,
        output i_dsc_rw, i_psc_rw, i_l2_rw,
        output i_dsc_addr, i_psc_addr, i_l2_addr,
        output i_ddr_ready, i_ddr_beat,
        input  o_dsc_bus_available, o_psc_bus_available, o_l2_bus_available,
        input  o_dsc_done, o_psc_done, o_l2_done, o_grant_sel,
        input  o_ddr_op_en, o_ddr_op_cmd, o_ddr_op_addr, o_xfer_abort
    );

    modport slave (
        input  i_dsc_request, i_psc_request, i_l2_request,
        input  i_dsc_rw, i_psc_rw, i_l2_rw,
        input  i_dsc_addr, i_psc_addr, i_l2_addr,
        input  i_ddr_ready, i_ddr_beat,
        output o_dsc_bus_available, o_psc_bus_available, o_l2_bus_available,
        output o_dsc_done, o_psc_done, o_l2_done, o_grant_sel,
        output o_ddr_op_en, o_ddr_op_cmd, o_ddr_op_addr, o_xfer_abort
    );

endinterface

// File: rtl/mem_bus_prio_enc.sv
// Fixed-priority encoder: DSC > PSC > L2, REQ_NONE when nobody requests.
module mem_bus_prio_enc
    import mcu_bus_pkg::*;
(
    input  logic [2:0] req,
    output req_id_t    id
);

    always_comb begin
        id = REQ_NONE;
        if (req[0])      id = REQ_DSC;
        else if (req[1]) id = REQ_PSC;
        else if (req[2]) id = REQ_L2;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Burst-at-a-time arbiter between DSC/PSC/L2 caches and the DDR3 user port,
// with a turnaround gap whenever another requester waited during a burst.
module mem_bus_arbiter
    import mcu_bus_pkg::*;
#(
    parameter int BURST_LENTH = 8,
    parameter int ADDR_WIDTH  = 28,
    parameter int GAP_CYCLES  = 4
) (
    input  logic            clk_166M66,
    input  logic            mcu_sys_rst_n,
    mem_bus_arbiter_if.slave bus
);

    localparam int CW = (BURST_LENTH > 1) ? $clog2(BURST_LENTH) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LENTH - 1);
    localparam logic [GW-1:0] LAST_GAP  = GW'(GAP_CYCLES - 1);

    state_t                state;
    req_id_t               owner;
    req_id_t               winner;
    logic [CW-1:0]         beat_cnt;
    logic [GW-1:0]         gap_cnt;
    logic                  pend;
    logic [2:0]            req_vec;
    logic                  other_req;
    logic                  win_rw;
    logic [ADDR_WIDTH-1:0] win_addr;

    assign req_vec   = {bus.i_l2_request, bus.i_psc_request, bus.i_dsc_request};
    assign other_req = |(req_vec & ~id_mask(owner));

    mem_bus_prio_enc u_prio (
        .req (req_vec),
        .id  (winner)
    );

    always_comb begin
        win_rw   = 1'b0;
        win_addr = '0;
        case (winner)
            REQ_DSC: begin win_rw = bus.i_dsc_rw; win_addr = bus.i_dsc_addr; end
            REQ_PSC: begin win_rw = bus.i_psc_rw; win_addr = bus.i_psc_addr; end
            REQ_L2:  begin win_rw = bus.i_l2_rw;  win_addr = bus.i_l2_addr;  end
            default: begin win_rw = 1'b0;         win_addr = '0;             end
        endcase
    end

    always_ff @(posedge clk_166M66) begin
        if (!mcu_sys_rst_n) begin
            state     <= IDLE;
            owner     <= REQ_NONE;
            beat_cnt  <= '0;
            gap_cnt   <= '0;
            pend      <= 1'b0;
            bus.o_ddr_op_en   <= 1'b0;
            bus.o_ddr_op_cmd  <= 3'b000;
            bus.o_ddr_op_addr <= '0;
            bus.o_xfer_abort  <= 1'b0;
            bus.o_grant_sel   <= REQ_NONE;
            {bus.o_l2_bus_available, bus.o_psc_bus_available, bus.o_dsc_bus_available} <= 3'b000;
            {bus.o_l2_done, bus.o_psc_done, bus.o_dsc_done} <= 3'b000;
        end else begin
            bus.o_ddr_op_en  <= 1'b0;
            bus.o_xfer_abort <= 1'b0;
            {bus.o_l2_done, bus.o_psc_done, bus.o_dsc_done} <= 3'b000;

            case (state)
                IDLE: begin
                    pend <= 1'b0;
                    if (bus.i_ddr_ready && (winner != REQ_NONE)) begin
                        owner             <= winner;
                        state             <= CMD;
                        beat_cnt          <= '0;
                        bus.o_ddr_op_en   <= 1'b1;
                        bus.o_ddr_op_cmd  <= win_rw ? CMD_RD : CMD_WR;
                        bus.o_ddr_op_addr <= win_addr;
                        bus.o_grant_sel   <= winner;
                        {bus.o_l2_bus_available, bus.o_psc_bus_available, bus.o_dsc_bus_available} <= id_mask(winner);
                    end
                end

                CMD, XFER: begin
                    if (!bus.i_ddr_ready) begin
                        // Controller lost calibration: drop the burst without a done.
                        bus.o_xfer_abort <= 1'b1;
                        bus.o_grant_sel  <= REQ_NONE;
                        {bus.o_l2_bus_available, bus.o_psc_bus_available, bus.o_dsc_bus_available} <= 3'b000;
                        owner    <= REQ_NONE;
                        beat_cnt <= '0;
                        pend     <= 1'b0;
                        state    <= IDLE;
                    end else if (state == CMD) begin
                        pend  <= pend | other_req;
                        state <= XFER;
                    end else begin
                        pend <= pend | other_req;
                        if (bus.i_ddr_beat) begin
                            if (beat_cnt == LAST_BEAT) begin
                                {bus.o_l2_done, bus.o_psc_done, bus.o_dsc_done} <= id_mask(owner);
                                bus.o_grant_sel <= REQ_NONE;
                                {bus.o_l2_bus_available, bus.o_psc_bus_available, bus.o_dsc_bus_available} <= 3'b000;
                                owner    <= REQ_NONE;
                                beat_cnt <= '0;
                                pend     <= 1'b0;
                                gap_cnt  <= '0;
                                // A requester arriving on the last beat still counts as waiting.
                                state    <= (pend | other_req) ? GAP : IDLE;
                            end else begin
                                beat_cnt <= beat_cnt + CW'(1);
                            end
                        end
                    end
                end

                GAP: begin
                    pend <= 1'b0;
                    if (gap_cnt == LAST_GAP) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
